// File: rtl/ones_pkg.sv
// Shared definitions for the ones-count / thermometer-expand datapath pair.
package ones_pkg;

   localparam int W_DEF = 30;

   typedef enum logic [1:0] {IDLE, FILL, DONE} oe_state_t;

endpackage

// File: rtl/Counter.sv
// Library up/down counter with synchronous clear and parallel load.
module Counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   input  logic             up_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;

   // Clear wins over load, load wins over counting.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)    cnt_q <= '0;
      else if (clr_i)  cnt_q <= '0;
      else if (load_i) cnt_q <= load_val_i;
      else if (en_i)   cnt_q <= up_i ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/MagComp.sv
// Library unsigned magnitude comparator.
module MagComp #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             gt_o,
   output logic             eq_o
);

   assign gt_o = (a_i > b_i);
   assign eq_o = (a_i == b_i);

endmodule

// File: rtl/ShiftRegister.sv
// Library right-shift register: serial input enters at the MSB.
module ShiftRegister #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             din_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)   q_q <= '0;
      else if (clr_i) q_q <= '0;
      else if (en_i)  q_q <= {din_i, q_q[WIDTH-1:1]};
   end

   assign q_o = q_q;

endmodule

// File: rtl/ones_expand.sv
// Serial thermometer builder: turns a count n into a W-bit word (1<<n)-1,
// shifting one bit per clock so the word appears W edges after accept.
module ones_expand
   import ones_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = $clog2(W+1)
) (
   input  logic          clk,
   input  logic          reset_L,
   input  logic          count_ready,
   input  logic [CW-1:0] count,
   output logic          busy,
   output logic          word_ready,
   output logic [W-1:0]  d_out,
   output logic          err
);

   localparam logic [CW-1:0] W_C    = CW'(W);
   localparam logic [CW-1:0] LAST_C = CW'(W-1);

   oe_state_t state_q, state_d;

   logic          accept, filling, ins, last;
   logic          cnt_gt, cnt_eq, bc_gt, bc_eq;
   logic [CW-1:0] rem_q, bitcnt_q, rem_load;
   logic [W-1:0]  sr_q, sr_nxt;
   logic [W-1:0]  d_out_q;
   logic          err_q;
   logic          unused_sr_lsb;

   assign filling = (state_q == FILL);
   assign accept  = count_ready && !filling;
   assign ins     = (rem_q != '0);

   MagComp #(.WIDTH(CW)) u_cnt_cmp (
      .a_i  (count),
      .b_i  (W_C),
      .gt_o (cnt_gt),
      .eq_o (cnt_eq)
   );

   // Requests above W saturate to a full word.
   assign rem_load = (cnt_gt || cnt_eq) ? W_C : count;

   Counter #(.WIDTH(CW)) u_rem (
      .clk        (clk),
      .reset_L    (reset_L),
      .clr_i      (1'b0),
      .load_i     (accept),
      .load_val_i (rem_load),
      .en_i       (filling && ins),
      .up_i       (1'b0),
      .cnt_o      (rem_q)
   );

   Counter #(.WIDTH(CW)) u_bitcnt (
      .clk        (clk),
      .reset_L    (reset_L),
      .clr_i      (accept),
      .load_i     (1'b0),
      .load_val_i ('0),
      .en_i       (filling),
      .up_i       (1'b1),
      .cnt_o      (bitcnt_q)
   );

   MagComp #(.WIDTH(CW)) u_last_cmp (
      .a_i  (bitcnt_q),
      .b_i  (LAST_C),
      .gt_o (bc_gt),
      .eq_o (bc_eq)
   );

   // bitcnt stops at W-1 while filling, so >= is the same test as ==.
   assign last = bc_eq || bc_gt;

   ShiftRegister #(.WIDTH(W)) u_sr (
      .clk     (clk),
      .reset_L (reset_L),
      .clr_i   (accept),
      .en_i    (filling),
      .din_i   (ins),
      .q_o     (sr_q)
   );

   // The LSB is the cleared seed bit; it is shifted out on the final edge.
   assign sr_nxt        = {ins, sr_q[W-1:1]};
   assign unused_sr_lsb = sr_q[0];

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: state_d = accept ? FILL : IDLE;
         FILL:       state_d = last ? DONE : FILL;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         d_out_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (filling && last) d_out_q <= sr_nxt;
         if (accept)          err_q   <= cnt_gt;
      end
   end

   assign busy       = filling;
   assign word_ready = (state_q == DONE);
   assign d_out      = d_out_q;
   assign err        = err_q;

endmodule

// File: tb/tb_ones_expand.sv
// Bench for ones_expand (W=30): vector table plus back-to-back and reset cases,
// with a scoreboard checking every produced word.
module tb_ones_expand;

   localparam int W  = 30;
   localparam int CW = $clog2(W+1);

   logic          clk = 1'b0;
   logic          reset_L;
   logic          count_ready;
   logic [CW-1:0] count;
   logic          busy, word_ready, err;
   logic [W-1:0]  d_out;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int nwords = 0;

   typedef struct {
      int           n;
      logic [W-1:0] d;
      logic         e;
   } exp_t;

   typedef struct {
      logic [CW-1:0] cnt;
      logic [W-1:0]  d;
      logic          e;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[5];

   ones_expand #(.W(W)) dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .count_ready (count_ready),
      .count       (count),
      .busy        (busy),
      .word_ready  (word_ready),
      .d_out       (d_out),
      .err         (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   // Scoreboard consumer: every word_ready must match the oldest expectation.
   logic prev_wr = 1'b0;
   always @(negedge clk) begin
      if (reset_L && word_ready) begin
         nwords++;
         check("wr_pulse", 64'(prev_wr), 64'd0);
         if (sb.size() == 0) begin
            fail_now("unexpected_word");
         end else begin
            exp_t x;
            x = sb.pop_front();
            check("d_out", 64'(d_out), 64'(x.d));
            check("err", 64'(err), 64'(x.e));
            check("popcount", 64'($countones(d_out)), 64'((x.n > W) ? W : x.n));
         end
      end
      prev_wr = word_ready;
   end

   task automatic wait_word(output int lat);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (word_ready) begin
            lat = k;
            break;
         end
      end
      if (lat == 0) fail_now("word_timeout");
   endtask

   task automatic request(input logic [CW-1:0] cnt, input logic [W-1:0] d, input logic e);
      int lat;
      exp_t x;
      count       = cnt;
      count_ready = 1'b1;
      @(posedge clk); #1;
      count_ready = 1'b0;
      x.n = int'(cnt); x.d = d; x.e = e;
      sb.push_back(x);
      check("busy_after_accept", 64'(busy), 64'd1);
      check("err_at_accept", 64'(err), 64'(e));
      wait_word(lat);
      check("latency", 64'(lat), 64'(W));
      @(posedge clk); #1;
      check("wr_low_after", 64'(word_ready), 64'd0);
   endtask

   initial begin
      int t1, t2, seen;
      exp_t x;
      vecs[0] = '{cnt: 5'd5,  d: 30'h0000001F, e: 1'b0};
      vecs[1] = '{cnt: 5'd0,  d: 30'h00000000, e: 1'b0};
      vecs[2] = '{cnt: 5'd30, d: 30'h3FFFFFFF, e: 1'b0};
      vecs[3] = '{cnt: 5'd31, d: 30'h3FFFFFFF, e: 1'b1};
      vecs[4] = '{cnt: 5'd2,  d: 30'h00000003, e: 1'b0};

      reset_L     = 1'b0;
      count_ready = 1'b0;
      count       = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_wr", 64'(word_ready), 64'd0);
      check("rst_dout", 64'(d_out), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      reset_L = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) request(vecs[i].cnt, vecs[i].d, vecs[i].e);

      // Back-to-back: request held high; count wiggles mid-FILL without effect.
      count       = 5'd7;
      count_ready = 1'b1;
      @(posedge clk); #1;
      x.n = 7; x.d = 30'h7F; x.e = 1'b0;
      sb.push_back(x);
      count = 5'd20;
      t1 = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 20) count = 5'd3;
         if (word_ready) begin
            t1 = cyc;
            break;
         end
      end
      if (t1 == 0) fail_now("b2b_first_timeout");
      x.n = 3; x.d = 30'h7; x.e = 1'b0;
      sb.push_back(x);
      @(posedge clk); #1;
      count_ready = 1'b0;
      check("b2b_busy", 64'(busy), 64'd1);
      t2 = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (word_ready) begin
            t2 = cyc;
            break;
         end
      end
      if (t2 == 0) fail_now("b2b_second_timeout");
      else check("b2b_spacing", 64'(t2 - t1), 64'd31);
      @(posedge clk); #1;

      // Reset in the middle of a fill abandons the request.
      count       = 5'd12;
      count_ready = 1'b1;
      @(posedge clk); #1;
      count_ready = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("pre_rst_busy", 64'(busy), 64'd1);
      reset_L = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_wr", 64'(word_ready), 64'd0);
      check("midrst_dout", 64'(d_out), 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      seen = nwords;
      repeat (3) @(posedge clk);
      #1;
      reset_L = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("no_word_after_rst", 64'(nwords - seen), 64'd0);
      request(5'd1, 30'h1, 1'b0);

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
